input_conditioner: RTL and testbench



---
 rtl/input_conditioner.sv | 62 ++++++
 tb/tb_input_conditioner.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Two-flop synchroniser, per-channel stability-count debounce and registered
// single-cycle rise/fall pulses for raw board switches and buttons.
module input_conditioner #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] s1, s2;
  logic [WIDTH-1:0] level_d, rise_d, fall_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= '0;
      s2    <= '0;
      level <= '0;
      rise  <= '0;
      fall  <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      s1    <= raw_in;
      s2    <= s1;
      level <= level_d;
      rise  <= rise_d;
      fall  <= fall_d;
      cnt_q <= cnt_d;
    end
  end

  // Count only while s2 disagrees with level; any agreement discards the
  // partial count, so the counter is bounded by LAST and never wraps.
  always_comb begin
    level_d = level;
    rise_d  = '0;
    fall_d  = '0;
    cnt_d   = cnt_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (s2[i] == level[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == LAST) begin
        level_d[i] = s2[i];
        rise_d[i]  = s2[i];
        fall_d[i]  = ~s2[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner (WIDTH=8, STABLE_CYCLES=4): expected
// outputs are queued per edge when stimulus is applied and compared at that edge.
module tb_input_conditioner;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic [7:0] raw_in = 8'hFF;
  logic [7:0] level, rise, fall;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         c;
    logic [7:0] lvl;
    logic [7:0] rs;
    logic [7:0] fl;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  input_conditioner #(
    .WIDTH(8),
    .STABLE_CYCLES(4),
    .CNT_W(20)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .raw_in(raw_in),
    .level(level),
    .rise(rise),
    .fall(fall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_at(input int c, input logic [7:0] l, input logic [7:0] r,
                           input logic [7:0] f);
    exp_t e;
    e.c = c; e.lvl = l; e.rs = r; e.fl = f;
    sb.push_back(e);
  endtask

  task automatic quiet(input int from, input int to, input logic [7:0] l);
    for (int c = from; c <= to; c++) expect_at(c, l, 8'h00, 8'h00);
  endtask

  // One active edge, then compare everything the scoreboard holds for it.
  task automatic step();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    check($sformatf("overlap@%0d", cyc), {24'd0, rise & fall}, 32'd0);
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      e = sb.pop_front();
      check($sformatf("sb_cycle@%0d", cyc), e.c, cyc);
      check($sformatf("level@%0d", cyc), {24'd0, level}, {24'd0, e.lvl});
      check($sformatf("rise@%0d", cyc),  {24'd0, rise},  {24'd0, e.rs});
      check($sformatf("fall@%0d", cyc),  {24'd0, fall},  {24'd0, e.fl});
    end
  endtask

  task automatic run(input logic [7:0] v, input int n);
    raw_in = v;
    repeat (n) step();
  endtask

  // A held change sampled at edge k commits at k+5 with STABLE_CYCLES=4.
  task automatic commit_case(input logic [7:0] v, input logic [7:0] old_lvl);
    int k;
    k = cyc + 1;
    quiet(k, k + 4, old_lvl);
    expect_at(k + 5, v, v & ~old_lvl, old_lvl & ~v);
    quiet(k + 6, k + 8, v);
    run(v, 9);
  endtask

  initial begin
    int k;

    // Reset held with all inputs high
    quiet(1, 3, 8'h00);
    run(8'hFF, 3);
    rst_n = 1'b1;
    k = cyc + 1;
    quiet(k, k + 5, 8'h00);
    run(8'h00, 6);

    // Clean press and release on bit 4
    commit_case(8'h10, 8'h00);
    commit_case(8'h00, 8'h10);

    // 3-cycle glitch rejected
    k = cyc + 1;
    quiet(k, k + 7, 8'h00);
    run(8'h01, 3);
    run(8'h00, 5);

    // 4-cycle hold commits once, release commits 4 cycles later
    k = cyc + 1;
    quiet(k, k + 4, 8'h00);
    expect_at(k + 5, 8'h01, 8'h01, 8'h00);
    quiet(k + 6, k + 8, 8'h01);
    expect_at(k + 9, 8'h00, 8'h00, 8'h01);
    quiet(k + 10, k + 12, 8'h00);
    run(8'h01, 4);
    run(8'h00, 9);

    // Bounce on bit 5: one rise 5 edges after the final 0->1 sample (k+4)
    k = cyc + 1;
    quiet(k, k + 8, 8'h00);
    expect_at(k + 9, 8'h20, 8'h20, 8'h00);
    quiet(k + 10, k + 12, 8'h20);
    run(8'h20, 1);
    run(8'h00, 1);
    run(8'h20, 1);
    run(8'h00, 1);
    run(8'h20, 9);
    commit_case(8'h00, 8'h20);

    // Multi-channel press and release
    commit_case(8'h11, 8'h00);
    commit_case(8'h00, 8'h11);

    // Reset mid-pending on bit 1 while bit 6 is high
    commit_case(8'h40, 8'h00);
    k = cyc + 1;
    quiet(k, k + 3, 8'h40);
    run(8'h42, 4);
    #2 rst_n = 1'b0;
    #1;
    check("async_level", {24'd0, level}, 32'd0);
    check("async_rise",  {24'd0, rise},  32'd0);
    check("async_fall",  {24'd0, fall},  32'd0);
    k = cyc + 1;
    quiet(k, k + 1, 8'h00);
    run(8'h42, 2);
    rst_n = 1'b1;
    commit_case(8'h42, 8'h00);

    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
